nios_sys_stepper_sequencer: RTL
===============================

// Module: nios_sys_stepper_sequencer
// PURPOSE
//  Avalon-MM slave that drives a unipolar stepper. A 16-bit prescaler (DIVISION) sets the step rate.
//  A phase sequencer drives the 4 coil lines in wave, full or half-step mode, CW or CCW.
//  It runs for a programmed step count or continuously, and tracks a 16-bit signed position.
//  Sits in nios_sys beside the PIO peripherals, with coils[3:0] going to the ULN driver pins.
// PARAMETERS
//  DIV_W    16  prescaler/DIVISION width
//  CNT_W    16  STEP_COUNT and remaining-steps width
//  POS_W    16  position counter width (two's complement, wraps)
// PORTS
//  clk        in   1   system clock
//  reset      in   1   asynchronous, active-high reset
//  address    in   2   register select
//  chipselect in   1   slave select
//  write_n    in   1   active-low write strobe
//  writedata  in   32  write data
//  readdata   out  32  read data, combinational (0 wait states)
//  coils      out  4   coil drive {D,C,B,A}, 1 = energized
//  irq        out  1   only when STEPPER_SEQ_IRQ_EN is defined
// BEHAVIOUR
//  Register map (wr = chipselect & ~write_n):
//   0 DIVISION   [15:0] R/W, reset 0
//   1 CONTROL    W: [0]GO [1]STOP [2]DIR(1=index+1) [4:3]MODE(00 wave,01 full,1x half) [5]HOLD [6]IRQ_EN
//                R: stored DIR/MODE/HOLD/IRQ_EN; GO and STOP read 0
//   2 STEP_COUNT [15:0] R/W, reset 0; 0 = continuous
//   3 STATUS     R: [0]busy [1]done [31:16]position. W: [1]=1 clears done, [2]=1 zeroes position
//  Reset: every register 0; state IDLE; index 0; prescaler 0; coils=0000; irq=0.
//  FSM IDLE/RUN:
//   IDLE->RUN on a CONTROL write with GO=1 and STOP=0.
//   RUN->IDLE on STOP=1, or on the final step when STEP_COUNT!=0.
//  GO (from either state) does all of the following on the write edge:
//   reloads remaining <= STEP_COUNT; clears prescaler; aligns index.
//   Alignment: wave clears idx[0]; full sets idx[0]; half leaves idx unchanged.
//   Result: busy=1 and coils energized on the next cycle.
//  Pattern table idx0..7: 0001,0011,0010,0110,0100,1100,1000,1001.
//   Wave uses even idx only; full uses odd idx only. Step size is ±2 for wave/full, ±1 for half. idx wraps mod 8.
//  Prescaler: in RUN it counts 0..DIVISION.
//   tick when cnt>=DIVISION, then cnt<=0; step period is DIVISION+1 clks.
//   DIVISION==0: no ticks, cnt held at 0, outputs stay energized.
//   A DIVISION write during RUN takes effect immediately via the >= compare.
//  On tick: idx steps per DIR/MODE; position ±1 (wraps); if remaining!=0 then remaining-1.
//   Reaching 0 moves to IDLE with done=1 on the same edge as the last step.
//  Continuous mode (STEP_COUNT=0): runs until STOP, never sets done.
//  Coils: RUN -> table[idx]. IDLE -> table[idx] if HOLD=1, else 0000.
//  Simultaneous events:
//   GO+STOP in one write: STOP wins.
//   done-set and done-clear on the same edge: set wins.
//   position zero-write and tick on the same edge: result is 0 ±1 (tick applied after the zero).
//   DIR/MODE writes during RUN apply at the next tick. Wave/full realign at that tick by ±1 in the step direction.
//  Reset mid-run aborts immediately: coils=0000, busy=0, done=0.
// CONFIGURATION
//  STEPPER_SEQ_IRQ_EN defined:
//   irq port exists; irq = done & IRQ_EN (level), cleared via STATUS[1]; CONTROL[6] is R/W.
//  Not defined:
//   no irq port; CONTROL[6] reads 0 and writes are ignored.
// TESTING
//  1 Reset: assert reset -> coils=0000, all readdata 0, busy=0.
//  2 DIV=4, COUNT=3, full, DIR=1, GO at cycle N
//     -> coils 0011 at N+1; 0110 at N+6; 1100 at N+11; 1001 at N+16.
//     -> busy falls and done=1 at N+16; position=3.
//  3 Half-step, DIR=0, COUNT=0, DIV=1, idx 0
//     -> coils 1001,1000,1100... every 2 clks; STOP at N+10 -> IDLE, done stays 0.
//  4 HOLD=0 vs HOLD=1 after a 2-step wave run -> coils 0000 vs 0100 held in IDLE.
//  5 CONTROL write with GO=1 and STOP=1 -> stays IDLE.
//    GO during RUN -> remaining reloaded, prescaler restarts.
//    DIV=0 while RUN -> no steps, busy stays 1.
//  6 IRQ_EN defined, IRQ_EN=1, COUNT=1 -> irq=1 after the step.
//    Write STATUS=0x2 -> irq=0. Without the macro, CONTROL[6] reads 0.

Source files
------------

// File: rtl/nios_sys_stepper_sequencer.sv
// Avalon-MM stepper sequencer: prescaled wave/full/half-step coil drive with step count and position.
// Optional irq output and CONTROL[6] IRQ_EN bit are built only when STEPPER_SEQ_IRQ_EN is defined.
module nios_sys_stepper_sequencer #(
  parameter int DIV_W = 16,
  parameter int CNT_W = 16,
  parameter int POS_W = 16
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [1:0]  address,
  input  logic        chipselect,
  input  logic        write_n,
  input  logic [31:0] writedata,
  output logic [31:0] readdata,
  output logic [3:0]  coils
`ifdef STEPPER_SEQ_IRQ_EN
  ,output logic       irq
`endif
);

  typedef enum logic {IDLE = 1'b0, RUN = 1'b1} state_t;

  state_t             state_q, state_d;
  logic [DIV_W-1:0]   division_q, division_d;
  logic [CNT_W-1:0]   step_count_q, step_count_d;
  logic [CNT_W-1:0]   remaining_q, remaining_d;
  logic [DIV_W-1:0]   presc_q, presc_d;
  logic [POS_W-1:0]   position_q, position_d;
  logic [2:0]         idx_q, idx_d;
  logic [1:0]         mode_q, mode_d;
  logic               dir_q, dir_d;
  logic               hold_q, hold_d;
  logic               done_q, done_d;
  logic               irq_en_rd;

  logic wr, wr_ctrl, go, stop, tick, big_step, busy;
  logic [2:0] step_sz;

  assign wr      = chipselect & ~write_n;
  assign wr_ctrl = wr && (address == 2'd1);
  assign stop    = wr_ctrl & writedata[1];
  assign go      = wr_ctrl & writedata[0] & ~writedata[1];
  assign busy    = (state_q == RUN);

  // A tick is suppressed on the edge where GO or STOP takes over the sequencer.
  assign tick = busy && !go && !stop && (division_q != '0) && (presc_q >= division_q);

  // Wave/full keep their parity with a 2-step; a 1-step realigns after a mode change.
  assign big_step = ~mode_q[1] && (idx_q[0] == mode_q[0]);
  assign step_sz  = big_step ? 3'd2 : 3'd1;

  always_comb begin
    state_d      = state_q;
    division_d   = division_q;
    step_count_d = step_count_q;
    remaining_d  = remaining_q;
    presc_d      = presc_q;
    position_d   = position_q;
    idx_d        = idx_q;
    mode_d       = mode_q;
    dir_d        = dir_q;
    hold_d       = hold_q;
    done_d       = done_q;

    if (wr) begin
      case (address)
        2'd0: division_d   = writedata[DIV_W-1:0];
        2'd1: begin
          dir_d  = writedata[2];
          mode_d = writedata[4:3];
          hold_d = writedata[5];
        end
        2'd2: step_count_d = writedata[CNT_W-1:0];
        default: begin
          if (writedata[1]) done_d = 1'b0;
          if (writedata[2]) position_d = '0;
        end
      endcase
    end

    if (state_q == RUN) begin
      if (tick) begin
        presc_d    = '0;
        idx_d      = dir_q ? (idx_q + step_sz) : (idx_q - step_sz);
        position_d = dir_q ? (position_d + POS_W'(1)) : (position_d - POS_W'(1));
        if (remaining_q != '0) begin
          remaining_d = remaining_q - CNT_W'(1);
          if (remaining_q == CNT_W'(1)) begin
            state_d = IDLE;
            done_d  = 1'b1;
          end
        end
      end else if (division_q != '0) begin
        presc_d = presc_q + DIV_W'(1);
      end else begin
        presc_d = '0;
      end
    end else begin
      presc_d = '0;
    end

    if (stop) begin
      state_d = IDLE;
      presc_d = '0;
    end else if (go) begin
      state_d     = RUN;
      remaining_d = step_count_q;
      presc_d     = '0;
      if (!writedata[4]) idx_d = {idx_q[2:1], writedata[3]};
      else               idx_d = idx_q;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q      <= IDLE;
      division_q   <= '0;
      step_count_q <= '0;
      remaining_q  <= '0;
      presc_q      <= '0;
      position_q   <= '0;
      idx_q        <= '0;
      mode_q       <= '0;
      dir_q        <= 1'b0;
      hold_q       <= 1'b0;
      done_q       <= 1'b0;
    end else begin
      state_q      <= state_d;
      division_q   <= division_d;
      step_count_q <= step_count_d;
      remaining_q  <= remaining_d;
      presc_q      <= presc_d;
      position_q   <= position_d;
      idx_q        <= idx_d;
      mode_q       <= mode_d;
      dir_q        <= dir_d;
      hold_q       <= hold_d;
      done_q       <= done_d;
    end
  end

`ifdef STEPPER_SEQ_IRQ_EN
  logic irq_en_q;
  always_ff @(posedge clk or posedge reset) begin
    if (reset)        irq_en_q <= 1'b0;
    else if (wr_ctrl) irq_en_q <= writedata[6];
  end
  assign irq_en_rd = irq_en_q;
  assign irq       = done_q & irq_en_q;
`else
  assign irq_en_rd = 1'b0;
`endif

  function automatic logic [3:0] pattern(input logic [2:0] i);
    case (i)
      3'd0: pattern = 4'b0001;
      3'd1: pattern = 4'b0011;
      3'd2: pattern = 4'b0010;
      3'd3: pattern = 4'b0110;
      3'd4: pattern = 4'b0100;
      3'd5: pattern = 4'b1100;
      3'd6: pattern = 4'b1000;
      default: pattern = 4'b1001;
    endcase
  endfunction

  assign coils = (busy || hold_q) ? pattern(idx_q) : 4'b0000;

  always_comb begin
    readdata = '0;
    case (address)
      2'd0: readdata = 32'(division_q);
      2'd1: readdata = {25'b0, irq_en_rd, hold_q, mode_q, dir_q, 2'b00};
      2'd2: readdata = 32'(step_count_q);
      default: readdata = {16'(position_q), 14'b0, done_q, busy};
    endcase
  end

  logic unused_wdata;
  assign unused_wdata = ^writedata[31:16];

endmodule
